// File: rtl/reservation_station_pkg.sv
// Shared constants, operation names and entry types for the ALU
// reservation station.
package reservation_station_pkg;

  localparam int RS_DEPTH = 16;
  localparam int TAG_W    = 4;
  localparam int XLEN     = 32;
  localparam int NAME_W   = 32;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [XLEN-1:0]   word_t;
  typedef logic [NAME_W-1:0] name_t;

  localparam tag_t NO_TAG = '0;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  function automatic name_t mk_name(
    input logic [6:0] opc,
    input logic [2:0] f3,
    input logic [6:0] f7
  );
    return {15'd0, f7, f3, opc};
  endfunction

  typedef struct packed {
    tag_t  q;
    word_t v;
  } opnd_t;

  typedef struct packed {
    name_t name;
    tag_t  dest;
    opnd_t j;
    opnd_t k;
    word_t imm;
    word_t pc;
  } rs_entry_t;

  typedef struct packed {
    logic  valid;
    name_t name;
    tag_t  dest;
    word_t vj;
    word_t vk;
    word_t imm;
    word_t pc;
  } alu_out_t;

  // cdb0 has priority when both buses carry the awaited tag
  function automatic opnd_t snoop(
    input opnd_t o,
    input logic  c0v,
    input tag_t  c0t,
    input word_t c0d,
    input logic  c1v,
    input tag_t  c1t,
    input word_t c1d
  );
    opnd_t r;
    r = o;
    if (o.q != NO_TAG) begin
      if (c0v && c0t == o.q) begin
        r.q = NO_TAG;
        r.v = c0d;
      end else if (c1v && c1t == o.q) begin
        r.q = NO_TAG;
        r.v = c1d;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, broadcast and ALU-dispatch bundle around the
// reservation station.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic  rdy;
  logic  clr;

  logic  issue_valid;
  name_t issue_name;
  tag_t  issue_dest;
  word_t issue_vj;
  word_t issue_vk;
  tag_t  issue_qj;
  tag_t  issue_qk;
  word_t issue_imm;
  word_t issue_pc;
  logic  rs_full;

  logic  cdb0_valid;
  tag_t  cdb0_tag;
  word_t cdb0_value;
  logic  cdb1_valid;
  tag_t  cdb1_tag;
  word_t cdb1_value;

  logic  alu_valid;
  name_t alu_name;
  tag_t  alu_dest;
  word_t alu_vj;
  word_t alu_vk;
  word_t alu_imm;
  word_t alu_pc;

  modport slave (
    input  rdy, clr,
    input  issue_valid, issue_name, issue_dest,
    input  issue_vj, issue_vk, issue_qj, issue_qk,
    input  issue_imm, issue_pc,
    output rs_full,
    input  cdb0_valid, cdb0_tag, cdb0_value,
    input  cdb1_valid, cdb1_tag, cdb1_value,
    output alu_valid, alu_name, alu_dest,
    output alu_vj, alu_vk, alu_imm, alu_pc
  );

  modport master (
    output rdy, clr,
    output issue_valid, issue_name, issue_dest,
    output issue_vj, issue_vk, issue_qj, issue_qk,
    output issue_imm, issue_pc,
    input  rs_full,
    output cdb0_valid, cdb0_tag, cdb0_value,
    output cdb1_valid, cdb1_tag, cdb1_value,
    input  alu_valid, alu_name, alu_dest,
    input  alu_vj, alu_vk, alu_imm, alu_pc
  );

endinterface

// File: rtl/rs_priority_enc.sv
// Lowest-set-bit encoder: reports whether any request is set and
// the index of the lowest one.
module rs_priority_enc #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: holds issued ops until both operands
// are known, snoops two result buses, dispatches one op per cycle.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = RS_DEPTH
) (
  input logic clk,
  input logic rst,
  reservation_station_if.slave bus
);

  localparam int IW = $clog2(RS_SIZE);

  rs_entry_t          ent_q [RS_SIZE];
  rs_entry_t          ent_d [RS_SIZE];
  logic [RS_SIZE-1:0] busy_q;
  logic [RS_SIZE-1:0] busy_d;
  logic [RS_SIZE-1:0] free_v;
  logic [RS_SIZE-1:0] ready_v;
  alu_out_t           alu_q;
  alu_out_t           alu_d;
  rs_entry_t          inc;
  logic               free_ok;
  logic               ready_ok;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      ready_idx;

  assign free_v      = ~busy_q;
  assign bus.rs_full = &busy_q;

  always_comb begin
    ready_v = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_v[i] = busy_q[i]
                && ent_q[i].j.q == NO_TAG
                && ent_q[i].k.q == NO_TAG;
    end
  end

  rs_priority_enc #(.N(RS_SIZE)) u_free (
    .req   (free_v),
    .found (free_ok),
    .idx   (free_idx)
  );

  rs_priority_enc #(.N(RS_SIZE)) u_ready (
    .req   (ready_v),
    .found (ready_ok),
    .idx   (ready_idx)
  );

  // incoming op with same-cycle broadcast bypass applied
  always_comb begin
    inc.name = bus.issue_name;
    inc.dest = bus.issue_dest;
    inc.imm  = bus.issue_imm;
    inc.pc   = bus.issue_pc;
    inc.j = snoop({bus.issue_qj, bus.issue_vj},
                  bus.cdb0_valid, bus.cdb0_tag, bus.cdb0_value,
                  bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_value);
    inc.k = snoop({bus.issue_qk, bus.issue_vk},
                  bus.cdb0_valid, bus.cdb0_tag, bus.cdb0_value,
                  bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_value);
  end

  always_comb begin
    ent_d  = ent_q;
    busy_d = busy_q;
    alu_d  = alu_q;
    alu_d.valid = 1'b0;
    if (bus.clr) begin
      busy_d = '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_d[i].j = snoop(ent_q[i].j,
          bus.cdb0_valid, bus.cdb0_tag, bus.cdb0_value,
          bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_value);
        ent_d[i].k = snoop(ent_q[i].k,
          bus.cdb0_valid, bus.cdb0_tag, bus.cdb0_value,
          bus.cdb1_valid, bus.cdb1_tag, bus.cdb1_value);
      end
      if (ready_ok) begin
        alu_d.valid = 1'b1;
        alu_d.name  = ent_q[ready_idx].name;
        alu_d.dest  = ent_q[ready_idx].dest;
        alu_d.vj    = ent_q[ready_idx].j.v;
        alu_d.vk    = ent_q[ready_idx].k.v;
        alu_d.imm   = ent_q[ready_idx].imm;
        alu_d.pc    = ent_q[ready_idx].pc;
        busy_d[ready_idx] = 1'b0;
      end
      // free slot comes from pre-edge busy, never the one leaving now
      if (bus.issue_valid && free_ok) begin
        ent_d[free_idx]  = inc;
        busy_d[free_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      alu_q  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
    end else if (bus.rdy) begin
      busy_q <= busy_d;
      alu_q  <= alu_d;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign bus.alu_valid = alu_q.valid;
  assign bus.alu_name  = alu_q.name;
  assign bus.alu_dest  = alu_q.dest;
  assign bus.alu_vj    = alu_q.vj;
  assign bus.alu_vk    = alu_q.vk;
  assign bus.alu_imm   = alu_q.imm;
  assign bus.alu_pc    = alu_q.pc;

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed stimulus, a slot-level
// model of the station, and per-cycle output comparison.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int N = RS_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reservation_station_if b ();

  reservation_station #(.RS_SIZE(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_viol  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // slot model
  logic  m_busy [N];
  name_t m_name [N];
  tag_t  m_dest [N];
  tag_t  m_qj   [N];
  tag_t  m_qk   [N];
  word_t m_vj   [N];
  word_t m_vk   [N];
  word_t m_imm  [N];
  word_t m_pc   [N];

  logic  e_valid;
  name_t e_name;
  tag_t  e_dest;
  word_t e_vj, e_vk, e_imm, e_pc;

  function automatic logic m_full();
    for (int i = 0; i < N; i++)
      if (!m_busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic resolve(input tag_t q, input word_t v,
                         output tag_t nq, output word_t nv);
    nq = q;
    nv = v;
    if (q != 0) begin
      if (b.cdb0_valid && b.cdb0_tag == q) begin
        nq = 0;
        nv = b.cdb0_value;
      end else if (b.cdb1_valid && b.cdb1_tag == q) begin
        nq = 0;
        nv = b.cdb1_value;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      e_valid = 0;
      e_name = 0;
      e_dest = 0;
      e_vj = 0;
      e_vk = 0;
      e_imm = 0;
      e_pc = 0;
    end else if (b.rdy) begin
      if (b.issue_valid && m_full()) n_viol++;
      if (b.clr) begin
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        e_valid = 0;
      end else begin
        int d;
        int f;
        d = -1;
        f = -1;
        for (int i = N - 1; i >= 0; i--) begin
          if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0) d = i;
          if (!m_busy[i]) f = i;
        end
        e_valid = (d >= 0);
        if (d >= 0) begin
          e_name = m_name[d];
          e_dest = m_dest[d];
          e_vj   = m_vj[d];
          e_vk   = m_vk[d];
          e_imm  = m_imm[d];
          e_pc   = m_pc[d];
          m_busy[d] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
          if (m_busy[i]) begin
            resolve(m_qj[i], m_vj[i], m_qj[i], m_vj[i]);
            resolve(m_qk[i], m_vk[i], m_qk[i], m_vk[i]);
          end
        end
        if (b.issue_valid && f >= 0) begin
          m_busy[f] = 1'b1;
          m_name[f] = b.issue_name;
          m_dest[f] = b.issue_dest;
          m_imm[f]  = b.issue_imm;
          m_pc[f]   = b.issue_pc;
          resolve(b.issue_qj, b.issue_vj, m_qj[f], m_vj[f]);
          resolve(b.issue_qk, b.issue_vk, m_qk[f], m_vk[f]);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rs_full", 32'(b.rs_full), 32'(m_full()));
    chk("alu_valid", 32'(b.alu_valid), 32'(e_valid));
    if (e_valid || !rst) begin
      chk("alu_name", b.alu_name, e_name);
      chk("alu_dest", 32'(b.alu_dest), 32'(e_dest));
      chk("alu_vj", b.alu_vj, e_vj);
      chk("alu_vk", b.alu_vk, e_vk);
      chk("alu_imm", b.alu_imm, e_imm);
      chk("alu_pc", b.alu_pc, e_pc);
    end
  end

  task automatic idle();
    b.rdy = 1'b1;
    b.clr = 1'b0;
    b.issue_valid = 1'b0;
    b.issue_name = '0;
    b.issue_dest = '0;
    b.issue_vj = '0;
    b.issue_vk = '0;
    b.issue_qj = '0;
    b.issue_qk = '0;
    b.issue_imm = '0;
    b.issue_pc = '0;
    b.cdb0_valid = 1'b0;
    b.cdb0_tag = '0;
    b.cdb0_value = '0;
    b.cdb1_valid = 1'b0;
    b.cdb1_tag = '0;
    b.cdb1_value = '0;
  endtask

  task automatic iss(input name_t nm, input tag_t d,
                     input word_t vj, input word_t vk,
                     input tag_t qj, input tag_t qk,
                     input word_t imm, input word_t pc);
    b.issue_valid = 1'b1;
    b.issue_name = nm;
    b.issue_dest = d;
    b.issue_vj = vj;
    b.issue_vk = vk;
    b.issue_qj = qj;
    b.issue_qk = qk;
    b.issue_imm = imm;
    b.issue_pc = pc;
  endtask

  task automatic c0(input tag_t t, input word_t v);
    b.cdb0_valid = 1'b1;
    b.cdb0_tag = t;
    b.cdb0_value = v;
  endtask

  task automatic c1(input tag_t t, input word_t v);
    b.cdb1_valid = 1'b1;
    b.cdb1_tag = t;
    b.cdb1_value = v;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
    idle();
  endtask

  name_t addi;
  name_t add;
  name_t beq;

  initial begin
    addi = mk_name(OPC_OP_IMM, 3'd0, 7'd0);
    add  = mk_name(OPC_OP, 3'd0, 7'd0);
    beq  = mk_name(OPC_BRANCH, 3'd0, 7'd0);
    idle();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    // reset mid-stream with three waiting entries
    for (int i = 0; i < 3; i++) begin
      iss(add, 4'(i + 1), 0, 0, 4'd7, 0, 32'(i), 0);
      tick();
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_full", 32'(b.rs_full), 0);
    chk("rst_valid", 32'(b.alu_valid), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    c0(4'd7, 32'h77);
    tick();
    tick();
    chk("rst_nodisp1", 32'(b.alu_valid), 0);
    tick();
    chk("rst_nodisp2", 32'(b.alu_valid), 0);

    // independent ADDI
    iss(addi, 4'd3, 32'd5, 0, 0, 0, 32'd7, 32'h100);
    tick();
    chk("addi_lat0", 32'(b.alu_valid), 0);
    tick();
    chk("addi_valid", 32'(b.alu_valid), 1);
    chk("addi_vj", b.alu_vj, 32'd5);
    chk("addi_imm", b.alu_imm, 32'd7);
    chk("addi_dest", 32'(b.alu_dest), 3);
    tick();
    chk("addi_drop", 32'(b.alu_valid), 0);

    // wakeup from cdb1 two cycles after issue
    iss(add, 4'd6, 0, 32'd1, 4'd3, 0, 0, 32'h104);
    tick();
    tick();
    c1(4'd3, 32'h10);
    tick();
    chk("wake_lat0", 32'(b.alu_valid), 0);
    tick();
    chk("wake_valid", 32'(b.alu_valid), 1);
    chk("wake_vj", b.alu_vj, 32'h10);

    // same-cycle bypass
    iss(add, 4'd7, 0, 32'd1, 4'd3, 0, 0, 32'h108);
    c1(4'd3, 32'h10);
    tick();
    chk("byp_lat0", 32'(b.alu_valid), 0);
    tick();
    chk("byp_valid", 32'(b.alu_valid), 1);
    chk("byp_vj", b.alu_vj, 32'h10);

    // dual broadcast, then both buses on one tag
    iss(beq, 4'd8, 0, 0, 4'd2, 4'd5, 32'hfffffff0, 32'h10c);
    tick();
    c0(4'd2, 32'hA);
    c1(4'd5, 32'hB);
    tick();
    tick();
    chk("dual_valid", 32'(b.alu_valid), 1);
    chk("dual_vj", b.alu_vj, 32'hA);
    chk("dual_vk", b.alu_vk, 32'hB);
    iss(add, 4'd9, 0, 32'd2, 4'd4, 0, 0, 32'h110);
    tick();
    c0(4'd4, 32'h44);
    c1(4'd4, 32'h55);
    tick();
    tick();
    chk("prio_valid", 32'(b.alu_valid), 1);
    chk("prio_vj", b.alu_vj, 32'h44);

    // fill all entries, overflow, drain in index order
    for (int i = 0; i < N; i++) begin
      iss(add, 4'(i), 0, 0, 4'd9, 0, 32'(i), 32'(i * 4));
      tick();
    end
    chk("full_set", 32'(b.rs_full), 1);
    iss(add, 4'd1, 0, 0, 0, 0, 32'h99, 0);
    tick();
    chk("full_hold", 32'(b.rs_full), 1);
    c0(4'd9, 32'h90);
    tick();
    chk("full_wake", 32'(b.alu_valid), 0);
    for (int i = 0; i < N; i++) begin
      tick();
      chk("drain_valid", 32'(b.alu_valid), 1);
      chk("drain_order", b.alu_imm, 32'(i));
      chk("drain_vj", b.alu_vj, 32'h90);
      if (i == 0) chk("full_clear", 32'(b.rs_full), 0);
    end
    tick();
    chk("drain_done", 32'(b.alu_valid), 0);

    // flush with five waiting entries and a same-cycle issue
    for (int i = 0; i < 5; i++) begin
      iss(add, 4'(i), 0, 0, 4'd6, 0, 32'(i), 0);
      tick();
    end
    iss(addi, 4'd2, 32'd1, 0, 0, 0, 32'd1, 0);
    c0(4'd6, 32'h66);
    b.clr = 1'b1;
    tick();
    chk("clr_full", 32'(b.rs_full), 0);
    chk("clr_valid", 32'(b.alu_valid), 0);
    c0(4'd6, 32'h66);
    tick();
    tick();
    chk("clr_nodisp", 32'(b.alu_valid), 0);

    // rdy low freezes outputs and ignores broadcasts
    iss(addi, 4'd5, 32'd3, 0, 0, 0, 32'h5A, 0);
    tick();
    tick();
    chk("frz_valid", 32'(b.alu_valid), 1);
    for (int i = 0; i < 2; i++) begin
      b.rdy = 1'b0;
      tick();
      chk("frz_hold", 32'(b.alu_valid), 1);
      chk("frz_imm", b.alu_imm, 32'h5A);
    end
    tick();
    chk("frz_rel", 32'(b.alu_valid), 0);
    iss(add, 4'd6, 0, 0, 4'd8, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      b.rdy = 1'b0;
      c0(4'd8, 32'h88);
      tick();
      chk("rdy_ign", 32'(b.alu_valid), 0);
    end
    tick();
    tick();
    chk("rdy_still", 32'(b.alu_valid), 0);
    c0(4'd8, 32'h81);
    tick();
    tick();
    chk("rdy_wake", 32'(b.alu_valid), 1);
    chk("rdy_vj", b.alu_vj, 32'h81);
    tick();

    chk("proto_viol", 32'(n_viol), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Receiving end of the decode/issue → RS interface.
- Buffers issued ALU-class instructions (I_BINARY, R_PRIMARY, U_LUI, U_AUIPC, SB_ALL, I_JALR, UJ_JAL) until both source operands are valid.
- Snoops the ROB-side and LSB result broadcasts to wake up waiting operands.
- Dispatches one ready instruction per cycle to the ALU. Signals full back to the issuer.

Parameters:
- RS_SIZE, 16, number of entries (power of two, ≥2)
- TAG_W, 4, dependency/destination tag width; tag 0 = "no dependency"
- XLEN, 32, operand/immediate width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low = freeze all state
- clr  in  1  flush from flow controller (mispredict)
- issue_valid  in  1  issuer's ready strobe; one instruction per cycle
- issue_name  in  32  packed opcode/funct3/funct7 operation name
- issue_dest  in  TAG_W  destination tag of the issued instruction
- issue_vj  in  XLEN  operand j value (meaningful when issue_qj==0)
- issue_vk  in  XLEN  operand k value (meaningful when issue_qk==0)
- issue_qj  in  TAG_W  operand j producer tag
- issue_qk  in  TAG_W  operand k producer tag
- issue_imm  in  XLEN  immediate, already sign-extended by the issuer
- issue_pc  in  XLEN  instruction PC (branches, AUIPC, JAL/JALR)
- rs_full  out  1  all entries busy
- cdb0_valid / cdb0_tag / cdb0_value  in  1 / TAG_W / XLEN  ROB-side result broadcast
- cdb1_valid / cdb1_tag / cdb1_value  in  1 / TAG_W / XLEN  LSB result broadcast
- alu_valid  out  1  dispatch strobe, one cycle
- alu_name / alu_dest  out  32 / TAG_W  operation and destination tag
- alu_vj / alu_vk / alu_imm / alu_pc  out  XLEN  operands

Behaviour:
- Reset (rst=0, async):
  - all entries busy=0.
  - alu_valid=0; alu_name, alu_dest, alu_vj, alu_vk, alu_imm, alu_pc = 0.
  - rs_full=0.
- rdy=0: no state or output register changes. alu_valid holds its value; the ALU also gates on rdy.
- Edge priority, when rdy=1: clr > (wakeup, dispatch, issue), all evaluated concurrently from the pre-edge state.
- clr=1:
  - all busy<=0 and alu_valid<=0 at that edge.
  - Any issue_valid or broadcast in the same cycle is discarded.
- Issue:
  - When issue_valid && !rs_full, write the lowest-index free entry. busy<=1.
  - Operand bypass: if issue_qj!=0 and it matches cdb0_tag (cdb0_valid) or cdb1_tag (cdb1_valid) in the same cycle, store the broadcast value with qj<=0. Same rule for qk.
  - issue_valid while rs_full: instruction is dropped, state unchanged. This is an issuer protocol violation and is flagged by a bench assertion.
- Wakeup:
  - Every busy entry with qj==cdb0_tag (cdb0_valid, qj!=0) loads vj<=cdb0_value, qj<=0. Same for cdb1, and same for qk.
  - If both buses carry the same tag, cdb0 wins.
  - Tag 0 never matches.
- Dispatch:
  - Ready = busy && qj==0 && qk==0, taken from registered state.
  - The lowest-index ready entry is selected. At the edge: alu_* <= entry fields, alu_valid<=1, entry busy<=0.
  - No ready entry: alu_valid<=0. The ALU has no backpressure.
- Latency:
  - Issue with no dependencies sampled at edge k → alu_valid=1 after edge k+1.
  - Wakeup at edge k → dispatch at edge k+1.
  - An entry woken or issued at edge k is never dispatched at edge k.
- Simultaneous dispatch and issue:
  - The freed slot is not reusable until the next edge.
  - rs_full is computed combinationally from registered busy bits, so it deasserts the cycle after dispatch from a full RS.
- Wrap/ordering: no age ordering. Lowest index wins. Starvation is impossible because the ALU accepts every cycle.
- rs_full = &busy (combinational).

Decomposition:
- Shared package (constants.v): RS_SIZE, TAG_W, NO_TAG=0, existing opcode/name encodings.
- One sub-module, rs_priority_enc: parameterised lowest-set-bit encoder. It outputs found plus index and is instantiated twice, for the free-slot search and the ready-slot search.

Test Plan:
- Reset: hold rst=0 mid-stream with 3 busy entries, release → rs_full=0, alu_valid=0, no dispatch for 2 cycles with no issue.
- Independent issue: ADDI with qj=0, vj=5, imm=7 at edge k → alu_valid=1 after edge k+1 with alu_vj=5, alu_imm=7, alu_dest=issue_dest; alu_valid=0 the following cycle.
- Wakeup and bypass:
  - ADD with qj=3, qk=0 issued. cdb1_valid, tag=3, value=0x10 two cycles later → dispatch the next cycle with alu_vj=0x10.
  - Repeat with the broadcast in the same cycle as issue → dispatch after edge k+1.
- Dual broadcast: entry waits on qj=2, qk=5. cdb0 tag=2 (0xA) and cdb1 tag=5 (0xB) in one cycle → dispatch next edge with vj=0xA, vk=0xB. Same tag 4 on both buses → cdb0 value taken.
- Full:
  - Issue 16 dependent instructions (qj=9) → rs_full=1. 17th issue_valid is dropped.
  - Broadcast tag 9 → dispatch one per cycle for 16 cycles, in index order 0..15.
  - rs_full=0 after the first dispatch.
- clr and rdy:
  - clr with 5 busy entries and a simultaneous issue → all empty, alu_valid=0, no later dispatch.
  - rdy=0 for 3 cycles during a pending wakeup broadcast → broadcast ignored, outputs frozen.
